// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bridging the execute stage to a request/grant data-memory bus.
// One access in flight; word-crossing accesses are optionally split into two bus transactions.
module lsu_bus_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TAG_W          = 5,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              exc_misalign,
    output logic              exc_illegal,
    output logic              busy,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP, S_EXC
    } state_t;

    state_t state, state_next;

    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [TAG_W-1:0]  r_tag;
    logic [31:0]       lo, hi;

    function automatic logic f_illegal(input logic we, input logic [2:0] f3);
        return (f3[1:0] == 2'b11) || (f3[2] && f3[1]) || (we && f3[2]);
    endfunction

    function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

    logic [1:0]        off;
    logic [2:0]        size;
    logic [3:0]        size_mask;
    logic [31:0]       data_mask;
    logic [2:0]        last_byte;
    logic              split;
    logic [7:0]        be_wide;
    logic [63:0]       wdata_wide;
    logic [31:0]       raw;
    logic [31:0]       load_ext;
    logic [ADDR_W-1:0] word_addr;

    assign off = r_addr[1:0];

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   begin size = 3'd1; size_mask = 4'b0001; data_mask = 32'h0000_00FF; end
            2'b01:   begin size = 3'd2; size_mask = 4'b0011; data_mask = 32'h0000_FFFF; end
            default: begin size = 3'd4; size_mask = 4'b1111; data_mask = 32'hFFFF_FFFF; end
        endcase
    end

    // Byte and data lanes are built 8 bytes wide so the second half of a split falls out of the upper word.
    assign last_byte  = {1'b0, off} + size - 3'd1;
    assign split      = MISALIGN_SPLIT && (last_byte > 3'd3);
    assign be_wide    = {4'b0000, size_mask} << off;
    assign wdata_wide = {32'h0, r_wdata & data_mask} << {off, 3'b000};
    assign raw        = 32'({hi, lo} >> {off, 3'b000});
    assign word_addr  = {r_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        case (r_funct3)
            3'b000:  load_ext = {{24{raw[7]}}, raw[7:0]};
            3'b001:  load_ext = {{16{raw[15]}}, raw[15:0]};
            3'b100:  load_ext = {24'h0, raw[7:0]};
            3'b101:  load_ext = {16'h0, raw[15:0]};
            default: load_ext = raw;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: the request and read-data registers are deliberately not reset; state gates every use of them.
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_tag    <= req_tag;
        end
        if (!rst && state == S_WAIT0 && mem_rvalid) lo <= mem_rdata;
        if (!rst && state == S_WAIT1 && mem_rvalid) hi <= mem_rdata;
    end

    // NOTE: every output and next-state term gets a default first, so no latches are inferred.
    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_data    = 32'h0;
        resp_tag     = '0;
        exc_misalign = 1'b0;
        exc_illegal  = 1'b0;
        busy         = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_be       = 4'b0000;
        mem_wdata    = 32'h0;
        if (!rst) begin
            busy = (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (f_illegal(req_we, req_funct3) ||
                            (!MISALIGN_SPLIT && f_misaligned(req_funct3, req_addr[1:0])))
                            state_next = S_EXC;
                        else
                            state_next = S_REQ0;
                    end
                end
                S_REQ0: begin
                    mem_req   = 1'b1;
                    mem_addr  = word_addr;
                    mem_we    = r_we;
                    mem_be    = be_wide[3:0];
                    mem_wdata = wdata_wide[31:0];
                    if (mem_gnt) begin
                        if (!r_we)     state_next = S_WAIT0;
                        else if (split) state_next = S_REQ1;
                        else           state_next = S_IDLE;
                    end
                end
                S_WAIT0: begin
                    if (mem_rvalid) state_next = split ? S_REQ1 : S_RESP;
                end
                S_REQ1: begin
                    mem_req   = 1'b1;
                    mem_addr  = word_addr + ADDR_W'(4);
                    mem_we    = r_we;
                    mem_be    = be_wide[7:4];
                    mem_wdata = wdata_wide[63:32];
                    if (mem_gnt) state_next = r_we ? S_IDLE : S_WAIT1;
                end
                S_WAIT1: begin
                    if (mem_rvalid) state_next = S_RESP;
                end
                S_RESP: begin
                    resp_valid = 1'b1;
                    resp_data  = load_ext;
                    resp_tag   = r_tag;
                    state_next = S_IDLE;
                end
                S_EXC: begin
                    exc_illegal  = f_illegal(r_we, r_funct3);
                    exc_misalign = !f_illegal(r_we, r_funct3);
                    state_next   = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed cases plus randomized accesses
// against a byte-addressed memory model and a size/offset-rule reference.
module tb_lsu_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, ns_req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        req_ready, resp_valid, exc_misalign, exc_illegal, busy, mem_req, mem_we;
    logic [31:0] resp_data, mem_addr, mem_wdata;
    logic [4:0]  resp_tag;
    logic [3:0]  mem_be;

    logic        ns_req_ready, ns_resp_valid, ns_exc_misalign, ns_exc_illegal, ns_busy, ns_mem_req, ns_mem_we;
    logic [31:0] ns_resp_data, ns_mem_addr, ns_mem_wdata;
    logic [4:0]  ns_resp_tag;
    logic [3:0]  ns_mem_be;

    always #5 clk = ~clk;

    lsu_bus_ctrl #(.ADDR_W(32), .TAG_W(5), .MISALIGN_SPLIT(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
        .exc_misalign(exc_misalign), .exc_illegal(exc_illegal), .busy(busy),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_bus_ctrl #(.ADDR_W(32), .TAG_W(5), .MISALIGN_SPLIT(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(ns_resp_valid), .resp_data(ns_resp_data), .resp_tag(ns_resp_tag),
        .exc_misalign(ns_exc_misalign), .exc_illegal(ns_exc_illegal), .busy(ns_busy),
        .mem_req(ns_mem_req), .mem_gnt(mem_gnt), .mem_addr(ns_mem_addr), .mem_we(ns_mem_we),
        .mem_be(ns_mem_be), .mem_wdata(ns_mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Byte-addressed memory; untouched bytes read back a fixed address-derived pattern.
    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rd_byte(a + 32'(i));
        return w;
    endfunction

    task automatic wr_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Reference load: gather size bytes starting at the byte address, then extend.
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < size_of(f3); i++) v[8*i +: 8] = rd_byte(a + 32'(i));
        if (f3 == 3'b000) return {{24{v[7]}}, v[7:0]};
        if (f3 == 3'b001) return {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    txn_t        txns[$];
    int          r_resp_cnt, r_resp_cycle, r_idle_cycle, r_exc_m, r_exc_i, r_stable_bad, r_busy_bad;
    bit          r_done;
    logic [31:0] r_resp_data;
    logic [4:0]  r_resp_tag;

    // Issues one request and plays the bus: grant after gnt_wait cycles, read data the cycle after grant.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] tag, input int gnt_wait);
        int          waited = 0;
        bit          in_req = 0, rd_pending = 0;
        logic [31:0] rd_addr = 32'h0;
        txn_t        cur = '0, now;
        txns.delete();
        r_resp_cnt = 0; r_resp_cycle = -1; r_idle_cycle = -1; r_exc_m = 0; r_exc_i = 0;
        r_stable_bad = 0; r_busy_bad = 0; r_done = 0;
        @(negedge clk);
        check("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_tag = tag;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = $urandom; req_wdata = $urandom; req_tag = 5'($urandom);
            mem_gnt = mem_req ? 1'b0 : 1'($urandom);
            mem_rvalid = mem_req ? 1'($urandom) : 1'b0;
            mem_rdata = $urandom;
            if (rd_pending) begin
                mem_rvalid = 1'b1; mem_rdata = rd_word(rd_addr); rd_pending = 0;
            end
            if (resp_valid) begin
                r_resp_cnt++; r_resp_cycle = cyc; r_resp_data = resp_data; r_resp_tag = resp_tag;
            end
            if (exc_misalign) r_exc_m++;
            if (exc_illegal)  r_exc_i++;
            if (mem_req) begin
                now = '{mem_addr, mem_be, mem_we, mem_wdata};
                if (!in_req) begin cur = now; in_req = 1; waited = 0; end
                else if (now !== cur) r_stable_bad++;
                if (!busy || req_ready) r_busy_bad++;
                if (waited >= gnt_wait) begin
                    mem_gnt = 1'b1; in_req = 0; txns.push_back(cur);
                    if (cur.we) begin
                        for (int i = 0; i < 4; i++) if (cur.be[i]) mem[cur.addr + 32'(i)] = cur.wdata[8*i +: 8];
                    end else begin
                        rd_pending = 1; rd_addr = cur.addr;
                    end
                end else begin
                    waited++;
                end
            end
            if (!busy) begin r_done = 1; r_idle_cycle = cyc; break; end
        end
        mem_gnt = 1'b0;
        check("access_completes", r_done, 1'b1);
    endtask

    logic [2:0] f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    initial begin
        int seen;
        rst = 1'b1; req_valid = 1'b0; ns_req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_tag = 5'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_ready_low", req_ready, 1'b0);
        check("rst_outputs_low", {resp_valid, mem_req, busy, exc_misalign, exc_illegal}, 5'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);

        // Aligned word load with zero-wait bus.
        wr_word(32'h100, 32'hDEADBEEF);
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 5'd7, 0);
        check("lw_data", r_resp_data, 32'hDEADBEEF);
        check("lw_tag", r_resp_tag, 5'd7);
        check("lw_latency", r_resp_cycle, 3);
        check("lw_resp_once", r_resp_cnt, 1);

        // Byte and halfword extension.
        wr_word(32'h100, 32'h80123456);
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 5'd1, 0);
        check("lb_sign", r_resp_data, 32'hFFFFFF80);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 5'd2, 0);
        check("lbu_zero", r_resp_data, 32'h00000080);
        do_access(1'b0, 3'b001, 32'h102, 32'h0, 5'd3, 0);
        check("lh_sign", r_resp_data, 32'hFFFF8012);

        // Split store.
        do_access(1'b1, 3'b010, 32'h102, 32'h11223344, 5'd0, 0);
        check("sw_split_ntxn", txns.size(), 2);
        if (txns.size() == 2) begin
            check("sw_txn0", {txns[0].addr, txns[0].be, txns[0].we, txns[0].wdata}, {32'h100, 4'b1100, 1'b1, 32'h33440000});
            check("sw_txn1", {txns[1].addr, txns[1].be, txns[1].we, txns[1].wdata}, {32'h104, 4'b0011, 1'b1, 32'h00001122});
        end
        check("sw_no_resp", r_resp_cnt, 0);

        // Aligned store timing: grant at c1, ready again at c2.
        do_access(1'b1, 3'b010, 32'h200, 32'h0BADF00D, 5'd0, 0);
        check("sw_idle_cycle", r_idle_cycle, 2);
        check("sw_mem", rd_word(32'h200), 32'h0BADF00D);

        // Split load.
        wr_word(32'h100, 32'hAABBCCDD);
        wr_word(32'h104, 32'h44332211);
        do_access(1'b0, 3'b010, 32'h103, 32'h0, 5'd4, 0);
        check("lw_split_data", r_resp_data, 32'h332211AA);
        check("lw_split_latency", r_resp_cycle, 5);
        check("lw_split_ntxn", txns.size(), 2);

        // Non-splitting instance rejects a misaligned halfword without bus traffic.
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b001; req_addr = 32'h101; ns_req_valid = 1'b1;
        check("ns_ready", ns_req_ready, 1'b1);
        @(negedge clk);
        ns_req_valid = 1'b0;
        check("ns_exc_misalign", {ns_exc_misalign, ns_exc_illegal, ns_mem_req}, 3'b100);
        @(negedge clk);
        check("ns_exc_one_cycle", {ns_exc_misalign, ns_mem_req, ns_req_ready}, 3'b001);

        // Grant withheld three cycles.
        wr_word(32'h300, 32'h12345678);
        do_access(1'b0, 3'b010, 32'h300, 32'h0, 5'd11, 3);
        check("gnt_wait_stable", r_stable_bad, 0);
        check("gnt_wait_busy", r_busy_bad, 0);
        check("gnt_wait_data", r_resp_data, 32'h12345678);
        check("gnt_wait_latency", r_resp_cycle, 6);

        // Illegal funct3 values.
        do_access(1'b0, 3'b011, 32'h100, 32'h0, 5'd0, 0);
        check("ill_011", {r_exc_i[7:0], r_exc_m[7:0], 8'(txns.size())}, {8'd1, 8'd0, 8'd0});
        do_access(1'b1, 3'b100, 32'h100, 32'h0, 5'd0, 0);
        check("ill_store_bu", {r_exc_i[7:0], r_exc_m[7:0], 8'(txns.size())}, {8'd1, 8'd0, 8'd0});

        // Reset while waiting for read data; the late rvalid must be ignored.
        wr_word(32'h100, 32'h01020304);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_tag = 5'd9;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_req0", mem_req, 1'b1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rst_mid_wait0", {busy, mem_req}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {req_ready, busy, resp_valid}, 3'b000);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rst_mid_idle", {req_ready, busy}, 2'b10);
        seen = 0;
        repeat (3) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        check("rst_mid_no_resp", seen, 0);
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 5'd9, 0);
        check("rst_mid_next_lw", {r_resp_data, 3'(r_resp_tag)}, {32'h01020304, 3'(5'd9)});

        // Randomized accesses against the reference rules.
        for (int k = 0; k < 40; k++) begin
            logic        we, ill, spl;
            logic [2:0]  f3;
            logic [31:0] a, wd, exp_v, got;
            logic [4:0]  tg;
            int          sz, be_total;
            we = 1'($urandom);
            f3 = ($urandom_range(0, 9) == 0) ? f3_tab[$urandom_range(5, 7)] : f3_tab[$urandom_range(0, 4)];
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                             : 32'h1000 + 32'($urandom_range(0, 63));
            wd = $urandom; tg = 5'($urandom);
            sz  = size_of(f3);
            ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && (f3 == 3'b100 || f3 == 3'b101));
            spl = !ill && (int'(a % 4) + sz > 4);
            exp_v = exp_load(f3, a);
            do_access(we, f3, a, wd, tg, $urandom_range(0, 2));
            check("rnd_stable", r_stable_bad + r_busy_bad, 0);
            if (ill) begin
                check("rnd_illegal", {r_exc_i[7:0], r_exc_m[7:0], 8'(txns.size())}, {8'd1, 8'd0, 8'd0});
            end else if (!we) begin
                check("rnd_load", {r_resp_cnt[7:0], r_resp_data, r_resp_tag}, {8'd1, exp_v, tg});
                check("rnd_load_ntxn", txns.size(), spl ? 2 : 1);
            end else begin
                be_total = 0;
                foreach (txns[i]) be_total += $countones(txns[i].be);
                got = 32'h0;
                for (int i = 0; i < sz; i++) got[8*i +: 8] = rd_byte(a + 32'(i));
                check("rnd_store_bytes", got, wd & ((sz == 4) ? 32'hFFFFFFFF : ((32'h1 << (8*sz)) - 32'h1)));
                check("rnd_store_txn", {8'(txns.size()), 8'(be_total), 8'(r_resp_cnt)}, {8'(spl ? 2 : 1), 8'(sz), 8'd0});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
